// File: rtl/signal_order_tx_pkg.sv
// Shared encodings for the signal path: signal classes, order FSM states and side codes.
// The comparator and the order transmitter both decode {out1,out2} through decode_pair().
package signal_order_tx_pkg;

    // Enumerator values equal the raw {out1,out2} pair so decode is a plain cast.
    typedef enum logic [1:0] {
        ClsSell    = 2'b00,
        ClsBuy     = 2'b01,
        ClsHold    = 2'b10,
        ClsInvalid = 2'b11
    } sig_class_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StSend = 2'b01,
        StCool = 2'b10
    } ord_state_e;

    localparam logic ORDER_SIDE_BUY  = 1'b1;
    localparam logic ORDER_SIDE_SELL = 1'b0;

    function automatic sig_class_e decode_pair(input logic out1, input logic out2);
        return sig_class_e'({out1, out2});
    endfunction

    // INVALID only raises the error flag; everything else sees it as HOLD.
    function automatic sig_class_e class_for_action(input sig_class_e cls);
        return (cls == ClsInvalid) ? ClsHold : cls;
    endfunction

endpackage

// File: rtl/signal_order_tx_if.sv
// Order request channel: valid/ready handshake carrying side and quantity.
interface signal_order_tx_if #(
    parameter int unsigned QTY_W = 16
) ();

    logic             ord_valid;
    logic             ord_ready;
    logic             ord_side;
    logic [QTY_W-1:0] ord_qty;

    modport master (
        output ord_valid,
        output ord_side,
        output ord_qty,
        input  ord_ready
    );

    modport slave (
        input  ord_valid,
        input  ord_side,
        input  ord_qty,
        output ord_ready
    );

endinterface

// File: rtl/signal_debounce.sv
// Registers the comparator pair, decodes it and only reports a class once it has held
// for STABLE_CYC consecutive cycles. Also keeps the sticky invalid-pair flag.
module signal_debounce
    import signal_order_tx_pkg::*;
#(
    parameter int unsigned STABLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sig_out1,
    input  logic       sig_out2,
    output sig_class_e stable_class,
    output logic       err_invalid
);

    localparam int unsigned   CntW   = $clog2(STABLE_CYC + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYC);

    sig_class_e      raw_q, raw_d;
    sig_class_e      prev_q, prev_d;
    sig_class_e      stable_q, stable_d;
    sig_class_e      cur_cls;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    always_comb begin
        raw_d   = decode_pair(sig_out1, sig_out2);
        cur_cls = class_for_action(raw_q);
        prev_d  = cur_cls;
        if (cur_cls != prev_q) begin
            cnt_d = CntW'(1);
        end else if (cnt_q == CntMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
        stable_d = (cnt_d == CntMax) ? cur_cls : stable_q;
        err_d    = err_q | (raw_q == ClsInvalid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q    <= ClsHold;
            prev_q   <= ClsHold;
            stable_q <= ClsHold;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            raw_q    <= raw_d;
            prev_q   <= prev_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign stable_class = stable_q;
    assign err_invalid  = err_q;

endmodule

// File: rtl/signal_order_tx.sv
// Turns debounced buy/sell signals into single order requests, tracking signed net
// position against a symmetric limit and enforcing a cooldown after each accepted order.
module signal_order_tx
    import signal_order_tx_pkg::*;
#(
    parameter int unsigned QTY_W        = 16,
    parameter int          ORDER_QTY    = 100,
    parameter int          MAX_POS      = 1000,
    parameter int unsigned STABLE_CYC   = 2,
    parameter int unsigned COOLDOWN_CYC = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sig_out1,
    input  logic                   sig_out2,
    signal_order_tx_if.master      ord,
    output logic signed [QTY_W:0]  position,
    output logic                   blocked,
    output logic                   err_invalid
);

    localparam int unsigned CoolW = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
    localparam logic signed [QTY_W:0] QtyS = (QTY_W + 1)'(ORDER_QTY);

    sig_class_e stable_class;

    ord_state_e            state_q, state_d;
    sig_class_e            last_q, last_d;
    logic                  side_q, side_d;
    logic [QTY_W-1:0]      qty_q, qty_d;
    logic signed [QTY_W:0] position_q, position_d;
    logic [CoolW-1:0]      cool_q, cool_d;
    logic                  blocked_q, blocked_d;

    int   pos_i;
    logic buy_ok;
    logic sell_ok;
    logic want_order;

    signal_debounce #(
        .STABLE_CYC (STABLE_CYC)
    ) u_debounce (
        .clk          (clk),
        .rst_n        (rst_n),
        .sig_out1     (sig_out1),
        .sig_out2     (sig_out2),
        .stable_class (stable_class),
        .err_invalid  (err_invalid)
    );

    // Limit check in 32-bit signed arithmetic so the sum can never wrap.
    assign pos_i      = int'(position_q);
    assign buy_ok     = (pos_i + ORDER_QTY) <= MAX_POS;
    assign sell_ok    = (pos_i - ORDER_QTY) >= -MAX_POS;
    assign want_order = ((stable_class == ClsBuy) || (stable_class == ClsSell)) &&
                        (stable_class != last_q);

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        side_d     = side_q;
        qty_d      = qty_q;
        position_d = position_q;
        cool_d     = cool_q;
        blocked_d  = 1'b0;

        // Re-arms the same side; applies in every state so a HOLD during cooldown counts.
        if (stable_class == ClsHold) begin
            last_d = ClsHold;
        end

        unique case (state_q)
            StIdle: begin
                if (want_order) begin
                    last_d = stable_class;
                    if ((stable_class == ClsBuy) ? buy_ok : sell_ok) begin
                        side_d  = (stable_class == ClsBuy) ? ORDER_SIDE_BUY : ORDER_SIDE_SELL;
                        qty_d   = QTY_W'(ORDER_QTY);
                        state_d = StSend;
                    end else begin
                        blocked_d = 1'b1;
                    end
                end
            end
            StSend: begin
                if (ord.ord_ready) begin
                    position_d = (side_q == ORDER_SIDE_BUY) ? position_q + QtyS
                                                            : position_q - QtyS;
                    cool_d     = '0;
                    state_d    = (COOLDOWN_CYC == 0) ? StIdle : StCool;
                end
            end
            StCool: begin
                if ((32'(cool_q) + 32'd1) >= COOLDOWN_CYC) begin
                    state_d = StIdle;
                end else begin
                    cool_d = cool_q + CoolW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            last_q     <= ClsHold;
            side_q     <= 1'b0;
            qty_q      <= '0;
            position_q <= '0;
            cool_q     <= '0;
            blocked_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            side_q     <= side_d;
            qty_q      <= qty_d;
            position_q <= position_d;
            cool_q     <= cool_d;
            blocked_q  <= blocked_d;
        end
    end

    assign ord.ord_valid = (state_q == StSend);
    assign ord.ord_side  = side_q;
    assign ord.ord_qty   = qty_q;
    assign position      = position_q;
    assign blocked       = blocked_q;

endmodule
